mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS datapath.
- Sequences the instruction-fetch unit (PC/NPC/IM), the instruction register, the register file, the ALU and the data memory over 3–5 cycles per instruction.
- Replaces single-cycle combinational control.
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j.

Parameters:
- OP_W, 6, opcode and funct field width.

Ports:
- clock  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- op  input  6  ir[31:26], from the instruction register (stable after FETCH)
- funct  input  6  ir[5:0]
- zero  input  1  ALU zero flag
- pc_wr  output  1  PC load enable
- npc_sel  output  1  1 = branch target selected in NPC
- jump_ctr  output  1  1 = jump target (tarAddr) selected in NPC
- ir_wr  output  1  instruction register load
- reg_wr  output  1  register file write enable
- reg_dst  output  1  1 = rd, 0 = rt
- alu_src  output  1  1 = extended immediate, 0 = rt data
- ext_op  output  1  1 = sign extend, 0 = zero extend
- alu_op  output  2  00 ADD, 01 SUB, 10 OR, 11 LUI (imm<<16)
- mem_wr  output  1  data memory write enable
- mem_to_reg  output  1  1 = memory data written back
- instr_done  output  1  one-cycle pulse on the final state of every instruction
- illegal  output  1  one-cycle pulse in DECODE for an unsupported op/funct
- state  output  4  current state, for debug

Behaviour:
- Moore FSM: one 4-bit state register, outputs decoded only from state, plus `zero` in BRANCH. Any output not listed for a state is 0.
- Reset (reset=0, async):
  - State goes to FETCH.
  - All write enables (pc_wr, ir_wr, reg_wr, mem_wr) are forced to 0 while reset is low.
  - All other outputs are 0 during reset, except state=0.
  - The first FETCH executes on the first rising edge after release.
- Reset mid-instruction aborts it. No partial register or memory write occurs after reset goes low.
- State encodings and outputs:
  - FETCH 0: pc_wr=1, ir_wr=1. Next state DECODE.
  - DECODE 1, next state by instruction:
    - op=000000 with funct 100001 or 100011: EXE_R.
    - ori (001101) or lui (001111): EXE_I.
    - lw (100011) or sw (101011): MEM_ADR.
    - beq (000100): BRANCH.
    - j (000010): JUMP.
    - Anything else: illegal=1, instr_done=1, next state FETCH, with no writes.
  - EXE_R 2: alu_src=0, alu_op=00 for addu, 01 for subu. Next state WB_R.
  - WB_R 3: reg_dst=1, reg_wr=1, instr_done=1, alu_op held as in EXE_R. Next state FETCH.
  - EXE_I 4: alu_src=1, ext_op=0, alu_op=10 for ori, 11 for lui. Next state WB_I.
  - WB_I 5: reg_dst=0, reg_wr=1, alu_src=1, alu_op held, instr_done=1. Next state FETCH.
  - MEM_ADR 6: alu_src=1, ext_op=1, alu_op=00. Next state MEM_RD for lw, MEM_WR for sw.
  - MEM_RD 7: alu_src=1, ext_op=1. Next state WB_MEM.
  - WB_MEM 8: reg_dst=0, mem_to_reg=1, reg_wr=1, instr_done=1. Next state FETCH.
  - MEM_WR 9: mem_wr=1, alu_src=1, ext_op=1, instr_done=1. Next state FETCH.
  - BRANCH 10: alu_src=0, alu_op=01, npc_sel=1, pc_wr=zero, instr_done=1. Next state FETCH.
  - JUMP 11: jump_ctr=1, pc_wr=1, instr_done=1. Next state FETCH.
  - States 12–15 (unreachable): all outputs 0, next state FETCH.
- Latency in cycles, counted from FETCH through the final state:
  - R-type and I-type: 4
  - lw: 5
  - sw: 4
  - beq and j: 3
  - illegal: 2
- reg_wr, mem_wr and pc_wr are each asserted for exactly one cycle per instruction. The exceptions are FETCH's pc_wr and a beq with zero=0, where BRANCH's pc_wr stays 0.

Test Plan:
- reset held low for 3 cycles, then released → state=0 and all enables 0 during reset; pc_wr=ir_wr=1 in the first cycle after release.
- op=000000, funct=100001 → state sequence 0,1,2,3; reg_wr=1 and reg_dst=1 only in state 3; alu_op=00; instr_done pulses once.
- lw (op=100011) → states 0,1,6,7,8; mem_to_reg=reg_wr=1 in state 8; mem_wr never 1. sw (op=101011) → states 0,1,6,9 with mem_wr=1 only in state 9.
- beq with zero=1, then beq with zero=0 → pc_wr=1 and npc_sel=1 in state 10 for the first; pc_wr=0 in state 10 for the second; both return to state 0.
- j, then op=111111 → j gives jump_ctr=pc_wr=1 in state 11. The illegal op gives illegal=1 in state 1, then state 0, with no reg_wr or mem_wr.
- lw in progress, reset pulsed low asynchronously in state 7 → state=0 immediately, reg_wr never asserted, normal fetch after release.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS datapath.
// Moore FSM sequencing fetch, decode, execute, memory and write-back over 3-5 cycles.
module mc_ctrl #(
  parameter int unsigned OP_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic [OP_W-1:0] funct,
  input  logic            zero,
  output logic            pc_wr,
  output logic            npc_sel,
  output logic            jump_ctr,
  output logic            ir_wr,
  output logic            reg_wr,
  output logic            reg_dst,
  output logic            alu_src,
  output logic            ext_op,
  output logic [1:0]      alu_op,
  output logic            mem_wr,
  output logic            mem_to_reg,
  output logic            instr_done,
  output logic            illegal,
  output logic [3:0]      state
);

  localparam logic [OP_W-1:0] OpSpecial = 6'b000000;
  localparam logic [OP_W-1:0] OpOri     = 6'b001101;
  localparam logic [OP_W-1:0] OpLui     = 6'b001111;
  localparam logic [OP_W-1:0] OpLw      = 6'b100011;
  localparam logic [OP_W-1:0] OpSw      = 6'b101011;
  localparam logic [OP_W-1:0] OpBeq     = 6'b000100;
  localparam logic [OP_W-1:0] OpJ       = 6'b000010;
  localparam logic [OP_W-1:0] FnAddu    = 6'b100001;
  localparam logic [OP_W-1:0] FnSubu    = 6'b100011;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExeR   = 4'd2,
    StWbR    = 4'd3,
    StExeI   = 4'd4,
    StWbI    = 4'd5,
    StMemAdr = 4'd6,
    StMemRd  = 4'd7,
    StWbMem  = 4'd8,
    StMemWr  = 4'd9,
    StBranch = 4'd10,
    StJump   = 4'd11
  } state_e;

  state_e state_q, state_d;

  // State register; async reset aborts any in-flight instruction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; everything is gated off while reset is low.
  always_comb begin
    state_d    = StFetch;
    pc_wr      = 1'b0;
    npc_sel    = 1'b0;
    jump_ctr   = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    alu_op     = 2'b00;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        pc_wr   = 1'b1;
        ir_wr   = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        if (op == OpSpecial && (funct == FnAddu || funct == FnSubu)) begin
          state_d = StExeR;
        end else if (op == OpOri || op == OpLui) begin
          state_d = StExeI;
        end else if (op == OpLw || op == OpSw) begin
          state_d = StMemAdr;
        end else if (op == OpBeq) begin
          state_d = StBranch;
        end else if (op == OpJ) begin
          state_d = StJump;
        end else begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
      end
      StExeR: begin
        alu_op  = (funct == FnSubu) ? 2'b01 : 2'b00;
        state_d = StWbR;
      end
      StWbR: begin
        reg_dst    = 1'b1;
        reg_wr     = 1'b1;
        instr_done = 1'b1;
        alu_op     = (funct == FnSubu) ? 2'b01 : 2'b00;
      end
      StExeI: begin
        alu_src = 1'b1;
        alu_op  = (op == OpLui) ? 2'b11 : 2'b10;
        state_d = StWbI;
      end
      StWbI: begin
        reg_wr     = 1'b1;
        alu_src    = 1'b1;
        alu_op     = (op == OpLui) ? 2'b11 : 2'b10;
        instr_done = 1'b1;
      end
      StMemAdr: begin
        alu_src = 1'b1;
        ext_op  = 1'b1;
        state_d = (op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        alu_src = 1'b1;
        ext_op  = 1'b1;
        state_d = StWbMem;
      end
      StWbMem: begin
        mem_to_reg = 1'b1;
        reg_wr     = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        mem_wr     = 1'b1;
        alu_src    = 1'b1;
        ext_op     = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_op     = 2'b01;
        npc_sel    = 1'b1;
        pc_wr      = zero;
        instr_done = 1'b1;
      end
      StJump: begin
        jump_ctr   = 1'b1;
        pc_wr      = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
    if (!reset) begin
      pc_wr      = 1'b0;
      npc_sel    = 1'b0;
      jump_ctr   = 1'b0;
      ir_wr      = 1'b0;
      reg_wr     = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      ext_op     = 1'b0;
      alu_op     = 2'b00;
      mem_wr     = 1'b0;
      mem_to_reg = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed instructions, async reset abort, random mix.
module tb_mc_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op    = '0;
  logic [5:0] funct = '0;
  logic       zero  = 1'b0;
  logic       pc_wr, npc_sel, jump_ctr, ir_wr, reg_wr, reg_dst, alu_src, ext_op;
  logic [1:0] alu_op;
  logic       mem_wr, mem_to_reg, instr_done, illegal;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  mc_ctrl #(.OP_W(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pc_wr      (pc_wr),
    .npc_sel    (npc_sel),
    .jump_ctr   (jump_ctr),
    .ir_wr      (ir_wr),
    .reg_wr     (reg_wr),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .ext_op     (ext_op),
    .alu_op     (alu_op),
    .mem_wr     (mem_wr),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: instruction class determines the state walk and per-instruction effects.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    int  exp_states[$];
    int  c_reg = 0, c_mem = 0, c_pc = 0, c_ir = 0, c_done = 0, c_ill = 0;
    bit  is_r, is_i, is_lw, is_sw, is_beq, is_j, is_ill;
    is_r   = (o == 6'h00) && (f == 6'h21 || f == 6'h23);
    is_i   = (o == 6'h0D) || (o == 6'h0F);
    is_lw  = (o == 6'h23);
    is_sw  = (o == 6'h2B);
    is_beq = (o == 6'h04);
    is_j   = (o == 6'h02);
    is_ill = !(is_r || is_i || is_lw || is_sw || is_beq || is_j);
    if (is_r)        exp_states = '{0, 1, 2, 3};
    else if (is_i)   exp_states = '{0, 1, 4, 5};
    else if (is_lw)  exp_states = '{0, 1, 6, 7, 8};
    else if (is_sw)  exp_states = '{0, 1, 6, 9};
    else if (is_beq) exp_states = '{0, 1, 10};
    else if (is_j)   exp_states = '{0, 1, 11};
    else             exp_states = '{0, 1};
    op = o; funct = f; zero = z;
    #1;
    foreach (exp_states[i]) begin
      check_eq("state", 32'(state), 32'(exp_states[i]));
      if (ir_wr) c_ir++;
      if (instr_done) begin
        c_done++;
        check_eq("done_last", 32'(i), 32'(exp_states.size() - 1));
      end
      if (illegal) c_ill++;
      if (reg_wr) begin
        c_reg++;
        check_eq("reg_dst", 32'(reg_dst), 32'(is_r));
        check_eq("mem_to_reg", 32'(mem_to_reg), 32'(is_lw));
        if (is_r) check_eq("alu_op_r", 32'(alu_op), (f == 6'h23) ? 32'd1 : 32'd0);
        if (is_i) check_eq("alu_op_i", 32'(alu_op), (o == 6'h0F) ? 32'd3 : 32'd2);
      end
      if (mem_wr) begin
        c_mem++;
        check_eq("sw_addr_path", 32'({alu_src, ext_op}), 32'd3);
      end
      if (pc_wr) begin
        c_pc++;
        if (i != 0) begin
          check_eq("npc_sel", 32'(npc_sel), 32'(is_beq));
          check_eq("jump_ctr", 32'(jump_ctr), 32'(is_j));
        end
      end
      @(posedge clock);
      #1;
    end
    check_eq("cnt_ir_wr", 32'(c_ir), 32'd1);
    check_eq("cnt_done", 32'(c_done), 32'd1);
    check_eq("cnt_illegal", 32'(c_ill), 32'(is_ill));
    check_eq("cnt_reg_wr", 32'(c_reg), 32'(is_r || is_i || is_lw));
    check_eq("cnt_mem_wr", 32'(c_mem), 32'(is_sw));
    check_eq("cnt_pc_wr", 32'(c_pc), 32'(1 + ((is_j || (is_beq && z)) ? 1 : 0)));
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h00};

    // Reset held low for three cycles: idle state, no enables.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_eq("rst_state", 32'(state), 32'd0);
      check_eq("rst_enables", 32'({pc_wr, ir_wr, reg_wr, mem_wr}), 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("first_fetch", 32'({pc_wr, ir_wr}), 32'd3);

    // Directed sequence from the plan.
    run_instr(6'h00, 6'h21, 1'b0);
    run_instr(6'h00, 6'h23, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0);
    run_instr(6'h2B, 6'h00, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1);
    run_instr(6'h04, 6'h00, 1'b0);
    run_instr(6'h02, 6'h00, 1'b0);
    run_instr(6'h3F, 6'h00, 1'b0);
    run_instr(6'h0D, 6'h00, 1'b0);
    run_instr(6'h0F, 6'h00, 1'b0);

    // lw aborted by an asynchronous reset while in MEM_RD.
    op = 6'h23; funct = 6'h00; zero = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("abort_pre_state", 32'(state), 32'd7);
    reset = 1'b0;
    #1;
    check_eq("abort_state", 32'(state), 32'd0);
    check_eq("abort_enables", 32'({pc_wr, ir_wr, reg_wr, mem_wr}), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      check_eq("abort_hold_state", 32'(state), 32'd0);
      check_eq("abort_no_reg_wr", 32'(reg_wr), 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("refetch", 32'({pc_wr, ir_wr}), 32'd3);
    run_instr(6'h23, 6'h00, 1'b0);

    // Randomised mix, including random (mostly illegal) opcodes and functs.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] o, f;
      int k;
      k = int'($urandom_range(0, 8));
      o = (k == 8) ? 6'($urandom) : ops[k];
      f = ($urandom_range(0, 1) == 0) ? (($urandom_range(0, 1) == 0) ? 6'h21 : 6'h23)
                                      : 6'($urandom);
      run_instr(o, f, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
